aes_mm_master: RTL and testbench
================================

AES_MM_MASTER -- requirements
Module: aes_mm_master

Interface
REQ-001 Parameter POLL_LIMIT, default 1024, SHALL be the maximum number of done-register reads per operation (used only with AES_MM_TIMEOUT_EN).
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CMD_VALID  input  1  command request; CMD_READY  output  1  SHALL be high only in IDLE.
REQ-005 CMD_KEY  input  128  AES key; CMD_MSG  input  128  encrypted message; both SHALL be captured when CMD_VALID && CMD_READY.
REQ-006 RES_VALID  output  1  result available; RES_READY  input  1  consumer accept.
REQ-007 RES_DATA  output  128  decrypted message; RES_ERR  output  1  timeout flag; BUSY  output  1  high whenever state != IDLE.
REQ-008 AVM_READ, AVM_WRITE, AVM_CS  output  1 each  Avalon-MM master strobes.
REQ-009 AVM_ADDR  output  4  word address; AVM_BYTE_EN  output  4  SHALL be constant 4'b1111.
REQ-010 AVM_WRITEDATA  output  32; AVM_READDATA  input  32; AVM_WAITREQUEST  input  1  stall from slave.

Function
REQ-011 States SHALL be IDLE, WR_KEY, WR_MSG, WR_START, POLL, RD_RES, CLR_START, RESP.
REQ-012 A transfer SHALL complete in the cycle its strobe is high and AVM_WAITREQUEST is low; strobe, address, data SHALL hold stable while AVM_WAITREQUEST is high.
REQ-013 AVM_CS SHALL equal AVM_READ | AVM_WRITE; AVM_READ and AVM_WRITE SHALL never be high together.
REQ-014 Read data SHALL be sampled in the completing cycle (zero read latency).
REQ-015 WR_KEY SHALL write addresses 0..3 with CMD_KEY[127:96], [95:64], [63:32], [31:0] in that order, via a 2-bit word counter.
REQ-016 WR_MSG SHALL write addresses 4..7 with CMD_MSG words in the same MSW-first order.
REQ-017 WR_START SHALL write 32'h1 to address 14.
REQ-018 POLL SHALL read address 15 each cycle; any nonzero value SHALL exit to RD_RES, zero SHALL stay in POLL.
REQ-019 RD_RES SHALL read addresses 8..11 into RES_DATA[127:96] .. [31:0].
REQ-020 CLR_START SHALL write 32'h0 to address 14, then enter RESP.
REQ-021 RESP SHALL hold RES_VALID high with RES_DATA, RES_ERR stable until RES_READY, then return to IDLE the next cycle.
REQ-022 With no wait states and done on first poll, RES_VALID SHALL rise 16 cycles after the accepting edge (4+4+1+1+4+1 transfers).
REQ-023 CMD_VALID outside IDLE SHALL be ignored; no command queueing.
REQ-024 Only one operation SHALL be outstanding; strobes SHALL be low in IDLE and RESP.

Reset
REQ-025 RESET SHALL immediately force IDLE, all strobes 0, AVM_ADDR 0, AVM_WRITEDATA 0, RES_DATA 0, RES_VALID 0, RES_ERR 0, BUSY 0, CMD_READY 0 while RESET is high.
REQ-026 Reset mid-operation SHALL discard captured key/message and partial result; no clear-start write SHALL be issued.

Configuration
REQ-027 With AES_MM_TIMEOUT_EN defined, reaching POLL_LIMIT zero reads in POLL SHALL go to CLR_START skipping RD_RES, with RES_DATA 0 and RES_ERR 1.
REQ-028 Without AES_MM_TIMEOUT_EN, POLL SHALL wait indefinitely, the poll counter SHALL not exist, and RES_ERR SHALL be tied 0.

Structure
REQ-029 Package aes_mm_pkg SHALL hold the state enum and address constants ADDR_KEY0=0, ADDR_MSG0=4, ADDR_DEC0=8, ADDR_START=14, ADDR_DONE=15.
REQ-030 The block SHALL be one module with no sub-module; counters and the FSM are local.

Verification
REQ-031 Key 128'h000102030405060708090a0b0c0d0e0f, msg 128'hdaec3055df058e1c39e814ea76f6747e, slave model done on first poll -> writes addr 0..7 MSW first, 1 to 14, 0 to 14, RES_VALID at cycle 16.
REQ-032 Slave asserts AVM_WAITREQUEST 3 cycles on addr 5 write -> addr/data held, sequence otherwise unchanged, RES_VALID at cycle 19.
REQ-033 Done reads 0 for 10 polls then 1 -> exactly 11 reads of addr 15, result equals slave words 8..11.
REQ-034 RES_READY held low 5 cycles -> RES_VALID, RES_DATA stable; CMD_READY low until cycle after RES_READY.
REQ-035 RESET pulsed during POLL -> strobes drop same cycle, IDLE, next command runs cleanly.
REQ-036 AES_MM_TIMEOUT_EN, POLL_LIMIT=4, done always 0 -> 4 polls, clear-start write, RES_ERR 1, RES_DATA 0.

Source files
------------

// File: rtl/aes_mm_pkg.sv
// Shared types and register map for the AES memory-mapped master.
package aes_mm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrKey,
        StWrMsg,
        StWrStart,
        StPoll,
        StRdRes,
        StClrStart,
        StResp
    } state_e;

    localparam logic [3:0] ADDR_KEY0  = 4'd0;
    localparam logic [3:0] ADDR_MSG0  = 4'd4;
    localparam logic [3:0] ADDR_DEC0  = 4'd8;
    localparam logic [3:0] ADDR_START = 4'd14;
    localparam logic [3:0] ADDR_DONE  = 4'd15;

    // Word idx 0 is the most significant 32 bits.
    function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] w;
        unique case (idx)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_mm_master.sv
// Avalon-MM master that drives an AES decrypt core: load key/msg, start, poll, read result.
// Optional poll timeout enabled by defining AES_MM_TIMEOUT_EN.
module aes_mm_master
    import aes_mm_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [127:0] cmd_key_i,
    input  logic [127:0] cmd_msg_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [127:0] res_data_o,
    output logic         res_err_o,
    output logic         busy_o,
    output logic         avm_read_o,
    output logic         avm_write_o,
    output logic         avm_cs_o,
    output logic [3:0]   avm_addr_o,
    output logic [3:0]   avm_byte_en_o,
    output logic [31:0]  avm_writedata_o,
    input  logic [31:0]  avm_readdata_i,
    input  logic         avm_waitrequest_i
);

    state_e         state_q, state_d;
    logic [127:0]   key_q, msg_q, res_q;
    logic [1:0]     cnt_q;
    logic           xfer;
    logic           accept;

    assign xfer          = avm_cs_o & ~avm_waitrequest_i;
    assign accept        = (state_q == StIdle) & cmd_valid_i;
    assign avm_byte_en_o = 4'hf;
    assign res_data_o    = res_q;

`ifdef AES_MM_TIMEOUT_EN
    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);
    logic [PollW-1:0] poll_q;
    logic             err_q;
    logic             poll_expired;

    assign poll_expired = (poll_q == PollW'(POLL_LIMIT - 1));
    assign res_err_o    = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else if (state_q == StPoll && xfer && avm_readdata_i == '0) begin
            poll_q <= poll_q + PollW'(1);
            if (poll_expired) err_q <= 1'b1;
        end
    end
`else
    assign res_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cmd_valid_i) state_d = StWrKey;
            StWrKey:    if (xfer && cnt_q == 2'd3) state_d = StWrMsg;
            StWrMsg:    if (xfer && cnt_q == 2'd3) state_d = StWrStart;
            StWrStart:  if (xfer) state_d = StPoll;
            StPoll: begin
                if (xfer) begin
                    if (avm_readdata_i != '0) state_d = StRdRes;
`ifdef AES_MM_TIMEOUT_EN
                    else if (poll_expired) state_d = StClrStart;
`endif
                end
            end
            StRdRes:    if (xfer && cnt_q == 2'd3) state_d = StClrStart;
            StClrStart: if (xfer) state_d = StResp;
            StResp:     if (res_ready_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        avm_read_o      = 1'b0;
        avm_write_o     = 1'b0;
        avm_addr_o      = '0;
        avm_writedata_o = '0;
        unique case (state_q)
            StWrKey: begin
                avm_write_o     = 1'b1;
                avm_addr_o      = ADDR_KEY0 + {2'b00, cnt_q};
                avm_writedata_o = word_sel(key_q, cnt_q);
            end
            StWrMsg: begin
                avm_write_o     = 1'b1;
                avm_addr_o      = ADDR_MSG0 + {2'b00, cnt_q};
                avm_writedata_o = word_sel(msg_q, cnt_q);
            end
            StWrStart: begin
                avm_write_o     = 1'b1;
                avm_addr_o      = ADDR_START;
                avm_writedata_o = 32'h1;
            end
            StPoll: begin
                avm_read_o = 1'b1;
                avm_addr_o = ADDR_DONE;
            end
            StRdRes: begin
                avm_read_o = 1'b1;
                avm_addr_o = ADDR_DEC0 + {2'b00, cnt_q};
            end
            StClrStart: begin
                avm_write_o = 1'b1;
                avm_addr_o  = ADDR_START;
            end
            default: ;
        endcase
        avm_cs_o    = avm_read_o | avm_write_o;
        busy_o      = (state_q != StIdle);
        cmd_ready_o = (state_q == StIdle) & ~rst_i;
        res_valid_o = (state_q == StResp);
    end

    // Word counter wraps 3->0 on its own, so it is ready for the next 4-word phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q <= '0;
            msg_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            key_q <= cmd_key_i;
            msg_q <= cmd_msg_i;
            res_q <= '0;
            cnt_q <= '0;
        end else if (xfer && (state_q == StWrKey || state_q == StWrMsg || state_q == StRdRes)) begin
            cnt_q <= cnt_q + 2'd1;
            if (state_q == StRdRes) begin
                unique case (cnt_q)
                    2'd0:    res_q[127:96] <= avm_readdata_i;
                    2'd1:    res_q[95:64]  <= avm_readdata_i;
                    2'd2:    res_q[63:32]  <= avm_readdata_i;
                    default: res_q[31:0]   <= avm_readdata_i;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_mm_master.sv
// Randomized bench for aes_mm_master with a behavioural Avalon slave and transaction log.
module tb_aes_mm_master;
    import aes_mm_pkg::*;

    localparam int unsigned PollLimit = 4;
    typedef logic [36:0] entry_t;  // {write, addr, data}

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy;
    logic [127:0] cmd_key, cmd_msg, res_data;
    logic         avm_read, avm_write, avm_cs, avm_waitreq;
    logic [3:0]   avm_addr, avm_byte_en;
    logic [31:0]  avm_writedata, avm_readdata;

    always #5 clk = ~clk;

    aes_mm_master #(.POLL_LIMIT(PollLimit)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_key_i        (cmd_key),
        .cmd_msg_i        (cmd_msg),
        .res_valid_o      (res_valid),
        .res_ready_i      (res_ready),
        .res_data_o       (res_data),
        .res_err_o        (res_err),
        .busy_o           (busy),
        .avm_read_o       (avm_read),
        .avm_write_o      (avm_write),
        .avm_cs_o         (avm_cs),
        .avm_addr_o       (avm_addr),
        .avm_byte_en_o    (avm_byte_en),
        .avm_writedata_o  (avm_writedata),
        .avm_readdata_i   (avm_readdata),
        .avm_waitrequest_i(avm_waitreq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave configuration, owned by the stimulus process.
    logic [31:0] mem [16];
    logic [31:0] done_word = 32'h1;
    int          cfg_zero = 0, cfg_wait = 0, wait_addr = 0;
    int          poll_base = 0, stall_base = 0;

    // Slave history, owned by the clocked slave processes.
    int          poll_cnt = 0, stall_cnt = 0;
    entry_t      xlog[$];
    int          proto_err = 0, hold_err = 0;
    bit          pend_log, pend_poll, pend_stall;
    entry_t      pend_entry;
    bit          prev_stall = 0;
    logic [3:0]  prev_addr;
    logic [31:0] prev_wd;
    logic        prev_wr, prev_rd;

    assign avm_waitreq  = avm_cs && (avm_addr == 4'(wait_addr)) && (stall_cnt - stall_base < cfg_wait);
    assign avm_readdata = (avm_addr == ADDR_DONE) ?
                          ((poll_cnt - poll_base < cfg_zero) ? 32'h0 : done_word) : mem[avm_addr];

    always @(negedge clk) begin
        pend_log   = 0;
        pend_poll  = 0;
        pend_stall = 0;
        if (prev_stall && (avm_addr !== prev_addr || avm_writedata !== prev_wd ||
                           avm_write !== prev_wr || avm_read !== prev_rd))
            hold_err++;
        if (avm_cs !== (avm_read | avm_write) || (avm_read & avm_write) || avm_byte_en !== 4'hf)
            proto_err++;
        if (avm_cs && !rst) begin
            if (avm_waitreq) pend_stall = 1;
            else begin
                pend_log   = 1;
                pend_entry = {avm_write, avm_addr, avm_write ? avm_writedata : avm_readdata};
                if (avm_read && avm_addr == ADDR_DONE) pend_poll = 1;
            end
        end
        prev_stall = avm_cs && avm_waitreq && !rst;
        prev_addr  = avm_addr;
        prev_wd    = avm_writedata;
        prev_wr    = avm_write;
        prev_rd    = avm_read;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (pend_log) xlog.push_back(pend_entry);
            if (pend_poll) poll_cnt <= poll_cnt + 1;
            if (pend_stall) stall_cnt <= stall_cnt + 1;
        end
    end

    // Issues one command and checks latency, result, handshake and the full bus transcript.
    task automatic run_op(input string nm, input logic [127:0] key, input logic [127:0] msg,
                          input logic [127:0] dec, input int zero_polls, input int waddr,
                          input int wn, input int ready_dly);
        entry_t       exp_q[$];
        int           base, n, polls, lat, waits, got_len;
        bit           to;
        logic [127:0] exp_data;
        to = 0;
`ifdef AES_MM_TIMEOUT_EN
        to = (zero_polls >= int'(PollLimit));
`endif
        for (int i = 0; i < 4; i++) mem[8 + i] = dec[(3 - i) * 32 +: 32];
        done_word  = $urandom | 32'h1;
        poll_base  = poll_cnt;
        stall_base = stall_cnt;
        cfg_zero   = zero_polls;
        wait_addr  = waddr;
        cfg_wait   = wn;
        base       = xlog.size();
        cmd_key    = key;
        cmd_msg    = msg;
        cmd_valid  = 1'b1;
        #1 check_eq({nm, ":cmd_ready_idle"}, cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = $urandom_range(0, 1);
        cmd_key   = {4{$urandom}};
        cmd_msg   = {4{$urandom}};
        check_eq({nm, ":busy"}, busy, 1'b1);
        n = 1;
        while (!res_valid && n < 2000) begin
            @(negedge clk);
            n++;
            if (n > 5) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        polls = to ? int'(PollLimit) : zero_polls + 1;
        waits = (to && waddr >= 8) ? 0 : wn;
        lat   = 4 + 4 + 1 + polls + (to ? 0 : 4) + 1 + 1 + waits;
        check_eq({nm, ":latency"}, n, lat);
        if (n >= 2000) return;
        exp_data = to ? 128'h0 : dec;
        for (int i = 0; i < ready_dly; i++) begin
            check_eq({nm, ":hold_valid"}, res_valid, 1'b1);
            check_eq({nm, ":hold_data"}, res_data, exp_data);
            check_eq({nm, ":hold_cmd_ready"}, cmd_ready, 1'b0);
            @(negedge clk);
        end
        check_eq({nm, ":res_data"}, res_data, exp_data);
        check_eq({nm, ":res_err"}, res_err, to);
        res_ready = 1'b1;
        #1 check_eq({nm, ":cmd_ready_resp"}, cmd_ready, 1'b0);
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({nm, ":valid_drop"}, res_valid, 1'b0);
        check_eq({nm, ":cmd_ready_back"}, cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'(i), key[(3 - i) * 32 +: 32]});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'(4 + i), msg[(3 - i) * 32 +: 32]});
        exp_q.push_back({1'b1, 4'd14, 32'h1});
        for (int i = 0; i < polls; i++)
            exp_q.push_back({1'b0, 4'd15, (i < zero_polls) ? 32'h0 : done_word});
        if (!to)
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 4'(8 + i), dec[(3 - i) * 32 +: 32]});
        exp_q.push_back({1'b1, 4'd14, 32'h0});
        got_len = xlog.size() - base;
        check_eq({nm, ":log_len"}, got_len, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_len; i++)
            check_eq({nm, ":log_entry"}, xlog[base + i], exp_q[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, clr_writes;
        logic [127:0] r;
        rst = 1'b1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        cmd_key = '0;
        cmd_msg = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        check_eq("rst:busy", busy, 1'b0);
        check_eq("rst:cmd_ready", cmd_ready, 1'b0);
        check_eq("rst:strobes", {avm_read, avm_write, avm_cs}, 3'b000);
        check_eq("rst:addr_wdata", {avm_addr, avm_writedata}, 36'h0);
        check_eq("rst:res", {res_valid, res_err, res_data}, 130'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("vec", 128'h000102030405060708090a0b0c0d0e0f,
               128'hdaec3055df058e1c39e814ea76f6747e, {4{$urandom}}, 0, 0, 0, 0);
        run_op("wait5", {4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 0, 5, 3, 0);
        run_op("poll10", {4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 10, 0, 0, 1);
        run_op("ready5", {4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 0, 0, 0, 5);

        // Reset while polling: strobes fall immediately, no clear-start write follows.
        poll_base = poll_cnt;
        cfg_zero  = 30;
        cfg_wait  = 0;
        base      = xlog.size();
        cmd_key   = {4{$urandom}};
        cmd_msg   = {4{$urandom}};
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("rstpoll:in_poll", {avm_read, avm_addr}, {1'b1, ADDR_DONE});
        #2 rst = 1'b1;
        #1;
        check_eq("rstpoll:strobes", {avm_read, avm_write, avm_cs}, 3'b000);
        check_eq("rstpoll:addr_wdata", {avm_addr, avm_writedata}, 36'h0);
        check_eq("rstpoll:busy_ready", {busy, cmd_ready, res_valid}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq("rstpoll:idle", {busy, cmd_ready}, 2'b01);
        repeat (3) @(negedge clk);
        clr_writes = 0;
        for (int i = base; i < xlog.size(); i++)
            if (xlog[i] == {1'b1, 4'd14, 32'h0}) clr_writes++;
        check_eq("rstpoll:no_clr", clr_writes, 0);
        run_op("after_rst", {4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 2, 9, 2, 1);

`ifdef AES_MM_TIMEOUT_EN
        run_op("timeout", {4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 1000, 2, 1, 2);
`endif

        for (int t = 0; t < 25; t++) begin
            r = {4{$urandom}};
            run_op("rand", {4{$urandom}}, {4{$urandom}}, r, $urandom_range(0, 6),
                   $urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        check_eq("protocol_violations", proto_err, 0);
        check_eq("stall_hold_violations", hold_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
